// File: rtl/mode_counter.sv
// Up/down counter with programmable modulus, variable step, synchronous load
// and a per-instance overflow policy (wrap, saturate or halt) with a sticky flag.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no counting this cycle (act=0 or load taken)
// UP    | last cycle counted up
// DOWN  | last cycle counted down
// HALT  | overflow under halt policy; frozen until ovf_clr or load
module mode_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_VALUE  = 255,
    parameter int STEP_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  act,
    input  logic                  updown,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  overflow,
    output logic [1:0]            state,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VALUE + 1);

    if (MAX_VALUE < 1 || MAX_VALUE > (2**WIDTH) - 1 || (2**STEP_WIDTH) - 1 > MAX_VALUE)
    begin : g_bad_params
        $error("mode_counter: illegal MAX_VALUE/STEP_WIDTH for WIDTH");
    end

    logic [WIDTH:0]     cnt_ext;
    logic [WIDTH:0]     step_ext;
    logic [WIDTH:0]     sum;
    logic               up_event;
    logic               dn_event;
    logic [WIDTH-1:0]   next_count;
    logic [1:0]         next_state;
    logic               next_ovf;

    assign cnt_ext  = {1'b0, count};
    assign step_ext = (WIDTH+1)'(step);
    assign sum      = cnt_ext + step_ext;
    assign up_event = sum > MAX_EXT;
    assign dn_event = cnt_ext < step_ext;

    always_comb begin
        next_count = count;
        next_state = state;
        next_ovf   = overflow;
        if (load) begin
            next_count = ({1'b0, load_value} > MAX_EXT) ? MAX_W : load_value;
            next_state = ST_IDLE;
            if (ovf_clr) next_ovf = 1'b0;
        end else if (state == ST_HALT) begin
            // act is ignored here even when ovf_clr releases the halt
            if (ovf_clr) begin
                next_state = ST_IDLE;
                next_ovf   = 1'b0;
            end
        end else if (act) begin
            next_state = updown ? ST_UP : ST_DOWN;
            if (ovf_clr) next_ovf = 1'b0;
            if (updown) begin
                if (!up_event) begin
                    next_count = WIDTH'(sum);
                end else begin
                    next_ovf = 1'b1;
                    if (mode == MODE_WRAP)     next_count = WIDTH'(sum - MOD_EXT);
                    else if (mode == MODE_SAT) next_count = MAX_W;
                    else                       next_state = ST_HALT;
                end
            end else begin
                if (!dn_event) begin
                    next_count = WIDTH'(cnt_ext - step_ext);
                end else begin
                    next_ovf = 1'b1;
                    if (mode == MODE_WRAP)     next_count = WIDTH'(cnt_ext + MOD_EXT - step_ext);
                    else if (mode == MODE_SAT) next_count = '0;
                    else                       next_state = ST_HALT;
                end
            end
        end else begin
            next_state = ST_IDLE;
            if (ovf_clr) next_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            count    <= next_count;
            overflow <= next_ovf;
            state    <= next_state;
        end
    end

    assign at_max = (count == MAX_W);
    assign at_min = (count == '0);

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised up/down counter with programmable modulus, variable step, synchronous load and a selectable overflow policy: wrap, saturate or halt. Next generation of the team's N-bit up/down counter. Used as a general event/position counter wherever the modulus is not a power of two or the overflow response must differ per instance. Overflow is reported as a sticky flag that firmware clears explicitly.

## Interface
- WIDTH, 8, count register width in bits.
- MAX_VALUE, 255, terminal count; legal range 1 .. 2**WIDTH-1; count range is 0..MAX_VALUE.
- STEP_WIDTH, 2, width of step input; must satisfy 2**STEP_WIDTH-1 <= MAX_VALUE (elaboration-time check).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- act  in  1  count enable for this cycle.
- updown  in  1  1 = count up, 0 = count down.
- step  in  STEP_WIDTH  increment/decrement amount; 0 = no change.
- mode  in  2  overflow policy: 00 wrap, 01 saturate, 10 halt, 11 treated as halt.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value for load; values > MAX_VALUE clamp to MAX_VALUE.
- ovf_clr  in  1  clears sticky overflow and releases HALT.
- count  out  WIDTH  current count, registered.
- overflow  out  1  sticky overflow/underflow flag, registered.
- state  out  2  00 IDLE, 01 UP, 10 DOWN, 11 HALT, registered.
- at_max  out  1  count == MAX_VALUE, decoded from registered count.
- at_min  out  1  count == 0, decoded from registered count.

## Operation
- Reset (rst=1, any time, asynchronous): count=0, overflow=0, state=IDLE; at_min=1, at_max=0.
- Per-cycle priority: load > HALT hold > act counting > idle.
- load=1: count <= clamp(load_value); state <= IDLE; act ignored that cycle; releases HALT; overflow unaffected unless ovf_clr is also 1.
- HALT: count frozen; act, updown and step ignored; mode changes do not release it. Exit only via ovf_clr (-> IDLE) or load. act in the same cycle as ovf_clr is ignored.
- act=1, not HALT, no load: state <= UP if updown=1, else DOWN. act=0: state <= IDLE, count held.
- Arithmetic uses WIDTH+1 bits internally; no truncation before the range check.
- Up event: count+step > MAX_VALUE. Down event: count < step. step=0 never produces an event.
- No event: count <= count +/- step.
- Event, wrap: up -> count+step-(MAX_VALUE+1); down -> count+(MAX_VALUE+1)-step. Set overflow.
- Event, saturate: up -> MAX_VALUE; down -> 0. Set overflow.
- Event, halt: count unchanged (pre-event value); state <= HALT. Set overflow.
- overflow is sticky. ovf_clr=1 clears it unless a new event occurs in the same cycle, in which case set wins and overflow stays 1.
- Mode is sampled each cycle; changing it mid-count affects only the next event.

## Timing
- All outputs change only on the clk rising edge or on rst assertion.
- Latency: act/load/ovf_clr sampled on edge N -> count, overflow, state updated after edge N, visible in cycle N+1.
- at_max/at_min follow count in the same cycle, with no extra latency.
- Back-to-back act gives one update per cycle. Direction reversal takes effect on the next edge with no bubble.
- rst deassertion: first counting edge is the first rising clk edge with rst=0.

## Test plan
Directed tests use WIDTH=4, MAX_VALUE=9, STEP_WIDTH=2.
- Reset mid-count at count=5 -> count=0, overflow=0, state=IDLE immediately, before any clock edge.
- Wrap, up: load 8, then act=1, updown=1, step=3 -> count=1, overflow=1, state=UP. Repeat at count=1 -> count=4, overflow stays 1.
- Saturate, down: load 2, then act=1, updown=0, step=3 -> count=0, overflow=1. Next cycle same stimulus -> count=0, overflow=1.
- Halt: load 7, then up with step=3 -> count=7, state=HALT, overflow=1.
  - 3 more act cycles -> count stays 7.
  - ovf_clr with act=1 -> state=IDLE, overflow=0, count=7.
- Priority and clamping:
  - load_value=15 with act=1 -> count=9, at_max=1, state=IDLE.
  - ovf_clr coincident with a wrap event -> overflow=1.
- Step and direction:
  - step=0 with act=1 at count=9, updown=1 -> count=9, overflow=0, state=UP.
  - Alternate updown each cycle with step=1 from count=4 -> 5, 4, 5, 4.
